// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// Optional resp_err appears only when ALU_SHARE_ARBITER_ILLEGAL_OP_EN is defined.
interface alu_share_arbiter_if #(
    parameter int N = 32
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_a0;
    logic [N-1:0] req_a1;
    logic [N-1:0] req_b0;
    logic [N-1:0] req_b1;
    logic [2:0]   req_op0;
    logic [2:0]   req_op1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [N-1:0] resp_y;
    logic         resp_zero;
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
    logic         resp_err;
`endif

    // Requester side: issues operations, consumes results.
    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
        output resp_ready,
        input  req_ready, resp_valid, resp_y, resp_zero
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
        , input resp_err
`endif
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
        input  resp_ready,
        output req_ready, resp_valid, resp_y, resp_zero
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
        , output resp_err
`endif
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one N-bit ALU between two requesters.
// Each accepted op: latch operands, hold ALU inputs ALU_LAT cycles, capture
// y/zero, return the result on the granted requester's response channel.
// Optional feature macro: ALU_SHARE_ARBITER_ILLEGAL_OP_EN (op 3'b111 answered
// immediately with resp_err=1 and never sent to the ALU).
module alu_share_arbiter #(
    parameter int N       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_share_arbiter_if.slave bus,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_y,
    input  logic         alu_zero
);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    logic          prio;
    logic          gnt_q;
    logic [CW-1:0] lat_cnt;

    logic          grant;
    logic          has_req;
    logic [N-1:0]  sel_a;
    logic [N-1:0]  sel_b;
    logic [2:0]    sel_op;

    // Round-robin grant, operand select and combinational request accept.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant   = prio;
        has_req = 1'b0;
        if (bus.req_valid[prio]) begin
            has_req = 1'b1;
        end else if (bus.req_valid[~prio]) begin
            grant   = ~prio;
            has_req = 1'b1;
        end
        sel_a  = grant ? bus.req_a1  : bus.req_a0;
        sel_b  = grant ? bus.req_b1  : bus.req_b0;
        sel_op = grant ? bus.req_op1 : bus.req_op0;
        bus.req_ready = 2'b00;
        if (state == IDLE && has_req) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // Sequencer FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            prio           <= 1'b0;
            gnt_q          <= 1'b0;
            lat_cnt        <= '0;
            bus.resp_valid <= 2'b00;
            bus.resp_y     <= '0;
            bus.resp_zero  <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= 3'b000;
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
            bus.resp_err   <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so every read sees pre-edge values.
            case (state)
                IDLE: begin
                    // In IDLE a pending request is always accepted this edge.
                    if (has_req) begin
                        gnt_q <= grant;
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
                        if (sel_op == 3'b111) begin
                            bus.resp_y     <= '0;
                            bus.resp_zero  <= 1'b0;
                            bus.resp_err   <= 1'b1;
                            bus.resp_valid <= 2'b01 << grant;
                            state          <= RESP;
                        end else begin
                            bus.resp_err <= 1'b0;
                            alu_a        <= sel_a;
                            alu_b        <= sel_b;
                            alu_op       <= sel_op;
                            lat_cnt      <= CW'(ALU_LAT - 1);
                            state        <= ISSUE;
                        end
`else
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_op  <= sel_op;
                        lat_cnt <= CW'(ALU_LAT - 1);
                        state   <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (lat_cnt == '0) begin
                        bus.resp_y     <= alu_y;
                        bus.resp_zero  <= alu_zero;
                        bus.resp_valid <= 2'b01 << gnt_q;
                        state          <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready[gnt_q]) begin
                        bus.resp_valid <= 2'b00;
                        prio           <= ~gnt_q;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a stub adder ALU.
// TB_LAT selects the DUT ALU_LAT; define ALU_SHARE_ARBITER_ILLEGAL_OP_EN to
// exercise the illegal-op path.
module tb_alu_share_arbiter #(
    parameter int TB_LAT = 1
);
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_op;
    logic        alu_zero;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    alu_share_arbiter_if #(.N(32)) bus ();

    alu_share_arbiter #(.N(32), .ALU_LAT(TB_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_zero(alu_zero)
    );

    // Stub ALU: add, ignore opcode.
    assign alu_y    = alu_a + alu_b;
    assign alu_zero = (alu_y == 32'd0);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] y;
        logic        z;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request on requester r; returns result and handshake-to-resp_valid latency.
    task automatic do_req(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input bit chk_alu,
                          output logic [31:0] y, output logic z, output int lat,
                          output logic err);
        int hs = -1;
        int rv = -1;
        y = '0; z = 1'b0; err = 1'b0; lat = -1;
        if (r == 0) begin bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; end
        else        begin bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; end
        bus.req_valid[r] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin hs = cyc; break; end
        end
        if (hs < 0) begin
            check("handshake_timeout", 0, 1);
            bus.req_valid[r] = 1'b0;
            return;
        end
        check("req_ready_onehot", bus.req_ready, 2'b01 << r);
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid[r]) begin rv = cyc; break; end
            if (chk_alu) begin
                check("alu_a_hold", alu_a, a);
                check("alu_b_hold", alu_b, b);
            end
        end
        if (rv < 0) begin
            check("resp_timeout", 0, 1);
            return;
        end
        check("resp_valid_onehot", bus.resp_valid, 2'b01 << r);
        y   = bus.resp_y;
        z   = bus.resp_zero;
        lat = rv - hs;
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
        err = bus.resp_err;
`endif
        @(posedge clk); #1;
    endtask

    logic [31:0] y;
    logic        z;
    logic        err;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 32'd5,         32'd7,         3'd0, 32'd12,  1'b0};
        vecs[1] = '{1, 32'd0,         32'd0,         3'd3, 32'd0,   1'b1};
        vecs[2] = '{0, 32'hFFFF_FFFF, 32'd1,         3'd0, 32'd0,   1'b1};
        vecs[3] = '{1, 32'd10,        32'd20,        3'd5, 32'd30,  1'b0};
        vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 3'd2, 32'd0,   1'b1};
        vecs[5] = '{1, 32'd123,       32'd456,       3'd1, 32'd579, 1'b0};

        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b11;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  bus.req_ready,  2'b00);
        check("rst_resp_valid", bus.resp_valid, 2'b00);
        check("rst_resp_y",     bus.resp_y,     32'd0);
        check("rst_resp_zero",  bus.resp_zero,  1'b0);
        check("rst_alu_a",      alu_a,          32'd0);
        check("rst_alu_b",      alu_b,          32'd0);
        check("rst_alu_op",     alu_op,         3'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 2'b00);
        @(posedge clk); #1;

        // Table-driven single requests.
        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, y, z, lat, err);
            check($sformatf("v%0d_y", i),      y,      vecs[i].y);
            check($sformatf("v%0d_zero", i),   z,      vecs[i].z);
            check($sformatf("v%0d_lat", i),    lat,    TB_LAT + 1);
            check($sformatf("v%0d_err", i),    err,    1'b0);
            check($sformatf("v%0d_alu_op", i), alu_op, vecs[i].op);
        end

        // Lone requester served back-to-back.
        begin
            int hs[2];
            int n = 0;
            bus.req_a0 = 32'd5; bus.req_b0 = 32'd7; bus.req_op0 = 3'd0;
            bus.req_valid[0] = 1'b1;
            for (int i = 0; i < 40 && n < 2; i++) begin
                @(negedge clk);
                if (bus.req_ready[0]) begin hs[n] = cyc; n++; end
                if (bus.resp_valid[0]) check("b2b_resp_y", bus.resp_y, 32'd12);
            end
            @(posedge clk); #1;
            bus.req_valid[0] = 1'b0;
            check("b2b_count", n, 2);
            if (n == 2) check("b2b_interval", hs[1] - hs[0], TB_LAT + 2);
            repeat (TB_LAT + 4) @(posedge clk);
            #1;
        end

        // Both requesters continuously valid: strict alternation from prio=0.
        rst = 1'b1; #2; rst = 1'b0;
        @(posedge clk); #1;
        begin
            int g[4];
            int n = 0;
            bus.req_a0 = 32'd1; bus.req_b0 = 32'd2; bus.req_op0 = 3'd0;
            bus.req_a1 = 32'd0; bus.req_b1 = 32'd0; bus.req_op1 = 3'd0;
            bus.req_valid = 2'b11;
            for (int i = 0; i < 60 && n < 4; i++) begin
                @(negedge clk);
                if (bus.resp_valid[0]) begin
                    check("alt_ch0_y", bus.resp_y, 32'd3);
                    check("alt_ch0_zero", bus.resp_zero, 1'b0);
                end
                if (bus.resp_valid[1]) begin
                    check("alt_ch1_y", bus.resp_y, 32'd0);
                    check("alt_ch1_zero", bus.resp_zero, 1'b1);
                end
                if (bus.req_ready != 2'b00) begin g[n] = int'(bus.req_ready[1]); n++; end
            end
            @(posedge clk); #1;
            bus.req_valid = 2'b00;
            check("alt_count", n, 4);
            if (n == 4) check("alt_order", {g[0][0], g[1][0], g[2][0], g[3][0]}, 4'b0101);
            repeat (TB_LAT + 4) @(posedge clk);
            #1;
        end

        // Response backpressure on channel 1.
        begin
            int rv = -1;
            bus.resp_ready = 2'b01;
            bus.req_a1 = 32'd9; bus.req_b1 = 32'd4; bus.req_op1 = 3'd0;
            bus.req_valid[1] = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.req_ready[1]) begin
                    @(posedge clk); #1;
                    bus.req_valid[1] = 1'b0;
                end
                if (bus.resp_valid[1]) begin rv = cyc; break; end
            end
            check("bp_resp_seen", rv >= 0, 1'b1);
            bus.req_a0 = 32'd1; bus.req_b0 = 32'd1;
            bus.req_valid[0] = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("bp_resp_valid", bus.resp_valid, 2'b10);
                check("bp_resp_y", bus.resp_y, 32'd13);
                check("bp_req_ready", bus.req_ready, 2'b00);
            end
            @(posedge clk); #1;
            bus.resp_ready = 2'b11;
            bus.req_valid[0] = 1'b0;
            @(negedge clk);
            check("bp_still_held", bus.resp_valid, 2'b10);
            @(negedge clk);
            check("bp_released", bus.resp_valid, 2'b00);
            @(posedge clk); #1;
        end

        // Asynchronous reset while the op sits in ISSUE.
        begin
            bus.req_a0 = 32'd2; bus.req_b0 = 32'd3; bus.req_op0 = 3'd4;
            bus.req_valid[0] = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.req_ready[0]) break;
            end
            @(posedge clk); #1;
            bus.req_valid[0] = 1'b0;
            check("mid_issue_alu_a", alu_a, 32'd2);
            rst = 1'b1;
            #1;
            check("mid_rst_resp_valid", bus.resp_valid, 2'b00);
            check("mid_rst_alu_a", alu_a, 32'd0);
            check("mid_rst_alu_op", alu_op, 3'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("mid_rst_no_resp", bus.resp_valid, 2'b00);
            end
            @(posedge clk); #1;
        end

`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
        do_req(0, 32'd3, 32'd4, 3'b111, 1'b0, y, z, lat, err);
        check("ill_lat",    lat,    1);
        check("ill_err",    err,    1'b1);
        check("ill_y",      y,      32'd0);
        check("ill_zero",   z,      1'b0);
        check("ill_alu_a",  alu_a,  32'd0);
        check("ill_alu_op", alu_op, 3'd0);
        do_req(0, 32'd3, 32'd4, 3'b000, 1'b1, y, z, lat, err);
        check("legal_err", err, 1'b0);
        check("legal_y",   y,   32'd7);
        check("legal_lat", lat, TB_LAT + 1);
`else
        do_req(0, 32'd3, 32'd4, 3'b111, 1'b1, y, z, lat, err);
        check("op7_y",      y,      32'd7);
        check("op7_lat",    lat,    TB_LAT + 1);
        check("op7_alu_op", alu_op, 3'b111);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one N-bit ALU (operands a/b, 3-bit op, results y/zero) between two requesters.
- Round-robin grant; valid/ready handshake on each request and each response channel.
- Sequences each operation: latch operands, drive ALU for ALU_LAT cycles, capture y/zero, return result to the granted requester.
- Sits between issue logic and the ALU instance in the datapath.

Parameters:
- N, 32, operand/result width.
- ALU_LAT, 1, cycles ALU inputs are held before y/zero are sampled (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accept.
- req_a0, req_a1  in  N  operand A, requester 0/1.
- req_b0, req_b1  in  N  operand B, requester 0/1.
- req_op0, req_op1  in  3  ALU opcode, requester 0/1.
- resp_valid  out  2  per-requester response valid.
- resp_ready  in  2  per-requester response accept.
- resp_y  out  N  result, shared by both response channels.
- resp_zero  out  1  zero flag, shared by both response channels.
- alu_a, alu_b  out  N  to ALU a/b.
- alu_op  out  3  to ALU op.
- alu_y  in  N  from ALU y.
- alu_zero  in  1  from ALU zero.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, prio=0, lat counter=0.
  - req_ready=0, resp_valid=0.
  - resp_y=0, resp_zero=0.
  - alu_a=0, alu_b=0, alu_op=000.
- Reset mid-transaction: in-flight op is dropped and no response is issued.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant g = prio if req_valid[prio], else the other requester if its req_valid is set.
  - req_ready[g]=1, combinational, only in IDLE. The other bit is 0.
  - On req_valid[g] & req_ready[g]: register a/b/op of g into alu_a/alu_b/alu_op, store g, counter=ALU_LAT-1, go to ISSUE.
  - No valid request: remain in IDLE.
- ISSUE:
  - alu_* held stable from registers.
  - Counter decrements each cycle.
  - On the cycle counter==0: capture alu_y→resp_y and alu_zero→resp_zero at the clock edge, go to RESP.
  - Occupancy is exactly ALU_LAT cycles.
- RESP:
  - resp_valid[g]=1 (registered). The other bit is 0.
  - resp_y/resp_zero held stable until the handshake completes.
  - On resp_ready[g]: resp_valid→0, prio←~g, go to IDLE.
  - Backpressure holds the arbiter in RESP indefinitely, and no new requests are accepted.
- Timing:
  - Latency from request handshake to resp_valid = ALU_LAT+1 cycles.
  - Minimum issue interval = ALU_LAT+2 cycles.
- Fairness:
  - When both requesters are continuously valid, grants strictly alternate.
  - A lone requester is served back-to-back.
- Input stability:
  - req_* inputs may change freely while req_ready=0.
  - Operands are sampled only at the handshake edge.
- Idle ALU: alu_a/alu_b/alu_op retain the last issued values (no toggling).

Optional Feature:
- Macro: ALU_SHARE_ARBITER_ILLEGAL_OP_EN.
- When defined:
  - Adds output resp_err (1 bit, reset 0).
  - A request with op==3'b111 is accepted normally but skips ISSUE (IDLE→RESP directly).
  - resp_err=1, resp_y=0, resp_zero=0 in that response.
  - alu_* are not updated.
  - resp_err=0 for all legal ops.
- When undefined:
  - No resp_err port.
  - op 111 is forwarded to the ALU like any other opcode.

Test Plan:
- Bench stub ALU: y=a+b, zero=(y==0), ALU_LAT=1.
- Test 1: rst pulse, then idle → all outputs 0. Assert rst asynchronously mid-ISSUE → resp_valid never rises, state back to IDLE.
- Test 2: requester 0 only, a=5, b=7, op=000 → handshake at cycle t, resp_valid[0]=1 at t+2, resp_y=12, resp_zero=0. With resp_ready=1, req_ready[0] is asserted again at t+3.
- Test 3: both requesters valid every cycle (r0: a=1,b=2; r1: a=0,b=0) → grant order r0, r1, r0, r1. Responses: resp_y=3 on channel 0, and resp_y=0 with resp_zero=1 on channel 1.
- Test 4: resp_ready[1]=0 for 10 cycles after resp_valid[1] → resp_y stable, req_ready=00 throughout, completes when resp_ready rises.
- Test 5: ALU_LAT=3 rebuild, a=32'hFFFFFFFF, b=1 → resp_y=0, resp_zero=1, latency 4 cycles. alu_a/alu_b stable for all 3 ISSUE cycles.
- Test 6: with ALU_SHARE_ARBITER_ILLEGAL_OP_EN defined, op=111 → resp_valid 1 cycle after the handshake, resp_err=1, resp_y=0. A following op=000 request gives resp_err=0.
